// File: rtl/ysyx_24100029_ifu_pkg.sv
// Shared constants and queue-entry layout for the prefetching instruction-fetch unit.
// The fault bit exists in the entry only when IFU_FAULT_REPORT_EN is defined.
package ysyx_24100029_ifu_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h3000_0000;
  localparam logic [2:0]  SIZE_4B          = 3'b010;
  localparam logic [1:0]  BURST_FIXED      = 2'b00;
  localparam logic [1:0]  RESP_OKAY        = 2'b00;

`ifdef IFU_FAULT_REPORT_EN
  typedef struct packed {
    logic        fault;
    logic [31:0] pc;
    logic [31:0] inst;
  } iq_entry_t;
`else
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } iq_entry_t;
`endif

  function automatic logic resp_is_fault(input logic [1:0] resp);
    return resp != RESP_OKAY;
  endfunction

endpackage

// File: rtl/ysyx_24100029_sync_fifo.sv
// Small synchronous FIFO with count output and a flush that beats push/pop.
// DEPTH need not be a power of two; pointers wrap explicitly.
module ysyx_24100029_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign full     = (count_reg == CNT_W'(DEPTH));
  assign empty    = (count_reg == '0);
  assign count    = count_reg;
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr_reg];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (do_pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      count_reg <= count_reg + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage carries no reset so it can map onto distributed/block RAM.
  always_ff @(posedge clock) begin
    if (do_push && !flush) mem[wr_ptr_reg] <= push_data;
  end

endmodule

// File: rtl/ysyx_24100029_ifu_prefetch.sv
// Prefetching IFU: multiple AXI4 reads in flight, instruction queue, redirect with stale-beat drop.
// Optional IFU_FAULT_REPORT_EN carries non-OKAY rresp through to out_fault.
module ysyx_24100029_ifu_prefetch
  import ysyx_24100029_ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = DEFAULT_RESET_PC,
  parameter int          FIFO_DEPTH      = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [3:0]  AXI_ID          = 4'h0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic        out_fault,
  output logic        arvalid,
  input  logic        arready,
  output logic [31:0] araddr,
  output logic [3:0]  arid,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  input  logic        rvalid,
  output logic        rready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic [3:0]  rid
);

  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int IQ_W  = $clog2(FIFO_DEPTH + 1);
  localparam int TAG_W = $clog2(MAX_OUTSTANDING + 1);

  logic [OUT_W-1:0] outstanding_reg, outstanding_next, drop_reg, drop_next;
  logic [31:0]      fetch_pc_reg, fetch_pc_next, araddr_reg, araddr_next, fetch_base;
  logic             arvalid_reg, arvalid_next, can_issue;
  logic             ar_hs, ar_stuck, r_beat, iq_push, iq_pop;
  logic [IQ_W-1:0]  iq_count, iq_count_next;
  logic             iq_full, iq_empty, tag_full, tag_empty;
  logic [TAG_W-1:0] tag_count;
  logic [31:0]      tag_head;
  iq_entry_t        iq_in, iq_head;

  assign ar_hs    = arvalid_reg & arready;
  assign ar_stuck = arvalid_reg & ~arready;
  assign r_beat   = rvalid & (outstanding_reg != '0);
  assign iq_push  = r_beat & (drop_reg == '0) & ~redirect_valid;
  assign iq_pop   = out_valid & out_ready;

  always_comb begin
    outstanding_next = outstanding_reg + OUT_W'(ar_hs) - OUT_W'(r_beat);
    drop_next        = drop_reg;
    // A request still waiting on arready will be accepted at its old address, so it is stale too.
    if (redirect_valid)
      drop_next = outstanding_next + OUT_W'(ar_stuck);
    else if (r_beat && drop_reg != '0)
      drop_next = drop_reg - OUT_W'(1);

    iq_count_next = redirect_valid ? '0 : iq_count + IQ_W'(iq_push) - IQ_W'(iq_pop);

    fetch_base = redirect_valid ? redirect_pc : fetch_pc_reg;
    can_issue  = !stall
              && (int'(outstanding_next) < MAX_OUTSTANDING)
              && (int'(outstanding_next) + int'(iq_count_next) < FIFO_DEPTH);

    arvalid_next  = arvalid_reg;
    araddr_next   = araddr_reg;
    fetch_pc_next = fetch_base;
    if (!ar_stuck) begin
      arvalid_next = can_issue;
      if (can_issue) begin
        araddr_next   = fetch_base;
        fetch_pc_next = fetch_base + 32'd4;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      outstanding_reg <= '0;
      drop_reg        <= '0;
      fetch_pc_reg    <= RESET_PC;
      araddr_reg      <= RESET_PC;
      arvalid_reg     <= 1'b0;
    end else begin
      outstanding_reg <= outstanding_next;
      drop_reg        <= drop_next;
      fetch_pc_reg    <= fetch_pc_next;
      araddr_reg      <= araddr_next;
      arvalid_reg     <= arvalid_next;
    end
  end

  always_comb begin
    iq_in      = '0;
    iq_in.pc   = tag_head;
    iq_in.inst = rdata;
`ifdef IFU_FAULT_REPORT_EN
    iq_in.fault = resp_is_fault(rresp);
`endif
  end

  ysyx_24100029_sync_fifo #(.WIDTH(32), .DEPTH(MAX_OUTSTANDING)) u_tag_q (
    .clock(clock), .reset(reset), .flush(1'b0),
    .push(ar_hs), .push_data(araddr_reg),
    .pop(r_beat), .pop_data(tag_head),
    .full(tag_full), .empty(tag_empty), .count(tag_count)
  );

  ysyx_24100029_sync_fifo #(.WIDTH($bits(iq_entry_t)), .DEPTH(FIFO_DEPTH)) u_inst_q (
    .clock(clock), .reset(reset), .flush(redirect_valid),
    .push(iq_push), .push_data(iq_in),
    .pop(iq_pop), .pop_data(iq_head),
    .full(iq_full), .empty(iq_empty), .count(iq_count)
  );

  assign out_valid = ~iq_empty;
  assign out_pc    = out_valid ? iq_head.pc : '0;
  assign out_inst  = out_valid ? iq_head.inst : '0;
  assign arvalid   = arvalid_reg;
  assign araddr    = araddr_reg;
  assign arid      = AXI_ID;
  assign arlen     = 8'd0;
  assign arsize    = SIZE_4B;
  assign arburst   = BURST_FIXED;
  assign rready    = 1'b1;

  logic unused_sigs;
`ifdef IFU_FAULT_REPORT_EN
  assign out_fault   = out_valid & iq_head.fault;
  assign unused_sigs = ^{rlast, rid, iq_full, tag_full, tag_empty, tag_count};
`else
  assign out_fault   = 1'b0;
  assign unused_sigs = ^{rlast, rid, rresp, iq_full, tag_full, tag_empty, tag_count};
`endif

  // A beat with nothing in flight has no tag; it is ignored by r_beat and flagged here.
  a_no_orphan_r: assert property (@(posedge clock) disable iff (reset)
    !(rvalid && outstanding_reg == '0));

endmodule

// File: tb/tb_ysyx_24100029_ifu_prefetch.sv
// Directed + randomized bench: AXI slave and decode consumer driven per cycle; the expected
// instruction stream is "consecutive pcs from the last redirect", each word a function of its address.
module tb_ysyx_24100029_ifu_prefetch;

  localparam int          DEPTH = 4;
  localparam int          MAXO  = 2;
  localparam logic [31:0] RPC   = 32'h3000_0000;
`ifdef IFU_FAULT_REPORT_EN
  localparam bit FAULT_EN = 1'b1;
`else
  localparam bit FAULT_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_valid, stall, out_valid, out_ready, out_fault;
  logic [31:0] redirect_pc, out_pc, out_inst, araddr, rdata;
  logic        arvalid, arready, rvalid, rready, rlast;
  logic [3:0]  arid, rid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst, rresp;

  always #5 clock = ~clock;

  ysyx_24100029_ifu_prefetch #(
    .RESET_PC(RPC), .FIFO_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .AXI_ID(4'h0)
  ) dut (
    .clock(clock), .reset(reset),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall(stall),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_inst(out_inst), .out_fault(out_fault),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
    .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .rlast(rlast), .rid(rid)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  req_t        slv_q[$];
  logic [31:0] ar_log[$];
  logic [31:0] pop_log[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          pops = 0;
  int          ar_pct = 100, r_pct = 100, rdy_pct = 100, lat_min = 1, lat_max = 1;
  logic [31:0] exp_pc = RPC;
  logic        prev_pend = 1'b0;
  logic [31:0] prev_addr = '0;
  logic        prev_r = 1'b0;
  logic        lat_chk = 1'b0;

  // Memory image seen by the slave: each word derived from its address.
  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5a5a_1234;
  endfunction

  function automatic logic [1:0] resp_of(input logic [31:0] a);
    if (a[4:2] == 3'd1) return 2'b10;
    if (a[6:2] == 5'd22) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic fault_of(input logic [31:0] a);
    return FAULT_EN && (resp_of(a) != 2'b00);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive slave/consumer, check outputs, update the reference model.
  task automatic tick();
    logic        hs_ar, hs_r, pop;
    logic [31:0] a;
    if (reset) begin
      slv_q.delete();
      arready   = 1'b0;
      rvalid    = 1'b0;
      out_ready = 1'b0;
    end else begin
      arready   = ($urandom_range(99) < ar_pct);
      rvalid    = (slv_q.size() > 0) && (slv_q[0].due <= cyc) && ($urandom_range(99) < r_pct);
      out_ready = ($urandom_range(99) < rdy_pct);
    end
    rdata = (slv_q.size() > 0) ? inst_of(slv_q[0].addr) : 32'hdead_beef;
    rresp = (slv_q.size() > 0) ? resp_of(slv_q[0].addr) : 2'b00;
    #1;
    hs_ar = arvalid & arready;
    hs_r  = rvalid;
    pop   = out_valid & out_ready;
    a     = araddr;
    if (!reset) begin
      if (prev_pend) begin
        check("ar_hold_valid", 32'(arvalid), 32'd1);
        check("ar_hold_addr", araddr, prev_addr);
      end
      if (lat_chk && prev_r) check("r_to_out_latency", 32'(out_valid), 32'd1);
      if (pop) begin
        check("out_pc", out_pc, exp_pc);
        check("out_inst", out_inst, inst_of(exp_pc));
        check("out_fault", 32'(out_fault), 32'(fault_of(exp_pc)));
        pop_log.push_back(out_pc);
        pops++;
      end
    end
    prev_pend = !reset && arvalid && !arready;
    prev_addr = araddr;
    prev_r    = hs_r;
    @(posedge clock);
    if (reset) begin
      exp_pc = RPC;
    end else begin
      if (hs_r) void'(slv_q.pop_front());
      if (hs_ar) begin
        slv_q.push_back('{addr: a, due: cyc + $urandom_range(lat_max, lat_min)});
        ar_log.push_back(a);
        check("outstanding_bound", (slv_q.size() <= MAXO) ? 32'd1 : 32'd0, 32'd1);
      end
      if (pop) exp_pc = exp_pc + 32'd4;
      if (redirect_valid) exp_pc = redirect_pc;
    end
    cyc++;
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    redirect_valid = 1'b0;
    stall          = 1'b0;
    #1;
    check("rst_arvalid", 32'(arvalid), 32'd0);
    check("rst_araddr", araddr, RPC);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_pc", out_pc, 32'd0);
    check("rst_out_inst", out_inst, 32'd0);
    check("rst_out_fault", 32'(out_fault), 32'd0);
    check("rst_rready", 32'(rready), 32'd1);
    repeat (2) tick();
    reset = 1'b0;
  endtask

  initial begin
    int base, p0, mark, guard;
    redirect_valid = 1'b0; redirect_pc = '0; stall = 1'b0; out_ready = 1'b0;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = '0; rlast = 1'b1; rid = '0;
    @(negedge clock);
    do_reset();
    check("arid", 32'(arid), 32'd0);
    check("arlen", 32'(arlen), 32'd0);
    check("arsize", 32'(arsize), 32'd2);
    check("arburst", 32'(arburst), 32'd0);

    // Streaming after reset with a 1-cycle slave.
    lat_chk = 1'b1;
    base = ar_log.size();
    tick();
    check("first_arvalid", 32'(arvalid), 32'd1);
    p0 = pops;
    repeat (13) tick();
    check("throughput", (pops - p0 >= 10) ? 32'd1 : 32'd0, 32'd1);
    check("ar_seq0", ar_log[base], 32'h3000_0000);
    check("ar_seq1", ar_log[base + 1], 32'h3000_0004);
    check("ar_seq2", ar_log[base + 2], 32'h3000_0008);
    lat_chk = 1'b0;

    // Decode stalled: credit limits issue to DEPTH requests.
    do_reset();
    rdy_pct = 0;
    base = ar_log.size();
    repeat (15) tick();
    check("full_ar_count", 32'(ar_log.size() - base), 32'(DEPTH));
    check("full_arvalid_low", 32'(arvalid), 32'd0);
    rdy_pct = 100;
    p0 = pops;
    tick();
    rdy_pct = 0;
    check("full_pop_taken", 32'(pops - p0), 32'd1);
    check("full_resume_arvalid", 32'(arvalid), 32'd1);
    rdy_pct = 100;
    repeat (10) tick();

    // Redirect with two requests in flight.
    do_reset();
    lat_min = 3; lat_max = 3;
    guard = 0;
    while (slv_q.size() != 2 && guard < 20) begin tick(); guard++; end
    check("two_outstanding", 32'(slv_q.size()), 32'd2);
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0000;
    tick();
    redirect_valid = 1'b0;
    check("redirect_flush", 32'(out_valid), 32'd0);
    mark = pop_log.size();
    guard = 0;
    while (pop_log.size() == mark && guard < 40) begin tick(); guard++; end
    check("redirect_first_pc", pop_log[mark], 32'h8000_0000);
    lat_min = 1; lat_max = 1;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    tick();
    redirect_valid = 1'b0;
    repeat (12) tick();

    // Redirect while an AR waits for arready.
    do_reset();
    ar_pct = 0;
    tick(); tick();
    check("pend_arvalid", 32'(arvalid), 32'd1);
    check("pend_addr", araddr, RPC);
    redirect_valid = 1'b1; redirect_pc = 32'h8000_1000;
    mark = pop_log.size();
    tick();
    redirect_valid = 1'b0;
    repeat (3) tick();
    base = ar_log.size();
    ar_pct = 100;
    guard = 0;
    while (ar_log.size() < base + 2 && guard < 20) begin tick(); guard++; end
    check("pend_old_addr", ar_log[base], RPC);
    check("pend_new_addr", ar_log[base + 1], 32'h8000_1000);
    repeat (6) tick();
    check("pend_first_pc", pop_log[mark], 32'h8000_1000);

    // Stall for five cycles mid-stream, then reset mid-burst.
    do_reset();
    repeat (6) tick();
    stall = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k >= 1) check("stall_no_ar", 32'(arvalid), 32'd0);
      tick();
    end
    stall = 1'b0;
    check("stall_still_low", 32'(arvalid), 32'd0);
    tick();
    check("stall_resume", 32'(arvalid), 32'd1);
    repeat (3) tick();
    do_reset();

    // Randomized traffic against the stream model.
    ar_pct = 70; r_pct = 70; rdy_pct = 70; lat_min = 1; lat_max = 4;
    p0 = pops;
    for (int i = 0; i < 3000; i++) begin
      stall          = ($urandom_range(99) < 10);
      redirect_valid = ($urandom_range(99) < 3);
      redirect_pc    = $urandom() & 32'hFFFF_FFFC;
      if ($urandom_range(3) == 0) redirect_pc = 32'hFFFF_FFF0 | (redirect_pc & 32'hC);
      tick();
    end
    redirect_valid = 1'b0;
    stall = 1'b0;
    check("random_progress", (pops - p0 > 300) ? 32'd1 : 32'd0, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
